// File: rtl/misr_pkg.sv
// Shared types and the MISR update function for misr_sig_ctrl.
package misr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompact,
        StDone
    } misr_state_e;

    // One compaction step, computed at the maximum supported width (64).
    // Callers zero-extend r/din/poly and truncate the result to N bits; the
    // upper bits never reach the lower N bits, so truncation is exact.
    function automatic logic [63:0] misr_next(input logic [63:0] r,
                                              input logic [63:0] din,
                                              input logic [63:0] poly);
        logic fb;
        fb = ^(r & poly);
        return {r[62:0], fb} ^ din;
    endfunction

endpackage

// File: rtl/misr_core.sv
// N-bit signature register with feedback, SEED load and compaction enable.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned   N    = 20,
    parameter logic [N-1:0]  POLY = '0,
    parameter logic [N-1:0]  SEED = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_seed_i,
    input  logic         en_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] sig_o,
    output logic [N-1:0] sig_next_o
);

    logic [N-1:0] sig_q, sig_d;

    // Next-state: SEED load wins over compaction, otherwise hold.
    always_comb begin
        sig_next_o = N'(misr_next(64'(sig_q), 64'(din_i), 64'(POLY)));
        sig_d      = sig_q;
        if (load_seed_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = sig_next_o;
        end
    end

    // Signature register, SEED on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/misr_sig_ctrl.sv
// MISR with session control: IDLE -> COMPACT -> DONE, pattern counter and
// optional golden-signature comparator (enabled by MISR_GOLDEN_CMP_EN).
module misr_sig_ctrl
    import misr_pkg::*;
#(
    parameter int unsigned   N            = 20,
    parameter logic [N-1:0]  POLY         = 20'h80003,
    parameter logic [N-1:0]  SEED         = 1,
    parameter int unsigned   NUM_PATTERNS = 1024,
    parameter logic [N-1:0]  GOLDEN       = 0,
    localparam int unsigned  CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din_valid,
    input  logic [N-1:0]     din,
    output logic [N-1:0]     signature,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    misr_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load_seed, en, last_word;
    logic [N-1:0]     sig_next;

    assign last_word = (count_q == CNT_W'(NUM_PATTERNS - 1));

    // FSM next-state and counter; start has priority over din_valid everywhere.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load_seed = 1'b0;
        en        = 1'b0;
        if (start) begin
            load_seed = 1'b1;
            count_d   = '0;
            state_d   = StCompact;
        end else if (state_q == StCompact && din_valid) begin
            en      = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (last_word) begin
                state_d = StDone;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    misr_core #(
        .N    (N),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_seed_i (load_seed),
        .en_i        (en),
        .din_i       (din),
        .sig_o       (signature),
        .sig_next_o  (sig_next)
    );

`ifdef MISR_GOLDEN_CMP_EN
    logic pass_q, pass_d;

    // Capture the comparison on the final word; cleared by start.
    always_comb begin
        pass_d = pass_q;
        if (start) begin
            pass_d = 1'b0;
        end else if (en && last_word) begin
            pass_d = (sig_next == GOLDEN);
        end
    end

    // Pass flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`else
    logic unused_golden;
    assign unused_golden = ^{GOLDEN, sig_next};
    assign pass          = 1'b0;
`endif

    assign count = count_q;
    assign busy  = (state_q == StCompact);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_misr_sig_ctrl.sv
// Directed bench for misr_sig_ctrl with small N=4 configurations.
module tb_misr_sig_ctrl;

`ifdef MISR_GOLDEN_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: POLY=1001, SEED=0001, 4 patterns, GOLDEN=1110.
    logic       start_a = 0, valid_a = 0;
    logic [3:0] din_a = 0, sig_a;
    logic [2:0] cnt_a;
    logic       busy_a, done_a, pass_a;

    // Instances B/C share stimulus: SEED=0, 2 patterns, GOLDEN 0 vs 1.
    logic       start_b = 0, valid_b = 0;
    logic [3:0] din_b = 0, sig_b, sig_c;
    logic [1:0] cnt_b, cnt_c;
    logic       busy_b, done_b, pass_b, busy_c, done_c, pass_c;

    misr_sig_ctrl #(.N(4), .POLY(4'b1001), .SEED(4'b0001), .NUM_PATTERNS(4),
                    .GOLDEN(4'b1110)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .din_valid(valid_a), .din(din_a),
        .signature(sig_a), .count(cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    misr_sig_ctrl #(.N(4), .POLY(4'b1001), .SEED(4'b0000), .NUM_PATTERNS(2),
                    .GOLDEN(4'h0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .din_valid(valid_b), .din(din_b),
        .signature(sig_b), .count(cnt_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    misr_sig_ctrl #(.N(4), .POLY(4'b1001), .SEED(4'b0000), .NUM_PATTERNS(2),
                    .GOLDEN(4'h1)) dut_c (
        .clk(clk), .rst(rst), .start(start_b), .din_valid(valid_b), .din(din_b),
        .signature(sig_c), .count(cnt_c), .busy(busy_c), .done(done_c), .pass(pass_c)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        logic [3:0] din;
        logic [3:0] sig;
        logic [2:0] cnt;
        logic       busy;
        logic       done;
        logic       pass;
    } vec_t;

    vec_t vecs[20];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs applied before the edge, outputs checked 1 time unit after it.
        vecs[0]  = '{0, 1, 4'hF, 4'b0001, 3'd0, 0, 0, 0};     // idle ignores valid
        vecs[1]  = '{1, 0, 4'h0, 4'b0001, 3'd0, 1, 0, 0};
        vecs[2]  = '{0, 1, 4'h0, 4'b0011, 3'd1, 1, 0, 0};
        vecs[3]  = '{0, 1, 4'h0, 4'b0111, 3'd2, 1, 0, 0};
        vecs[4]  = '{0, 1, 4'h0, 4'b1111, 3'd3, 1, 0, 0};
        vecs[5]  = '{0, 1, 4'h0, 4'b1110, 3'd4, 0, 1, CmpEn};
        vecs[6]  = '{0, 1, 4'h5, 4'b1110, 3'd4, 0, 1, CmpEn}; // frozen in DONE
        vecs[7]  = '{0, 0, 4'h0, 4'b1110, 3'd4, 0, 1, CmpEn};
        vecs[8]  = '{1, 0, 4'h0, 4'b0001, 3'd0, 1, 0, 0};     // second session
        vecs[9]  = '{0, 1, 4'h0, 4'b0011, 3'd1, 1, 0, 0};
        vecs[10] = '{0, 0, 4'h9, 4'b0011, 3'd1, 1, 0, 0};     // gaps
        vecs[11] = '{0, 0, 4'h0, 4'b0011, 3'd1, 1, 0, 0};
        vecs[12] = '{0, 1, 4'h0, 4'b0111, 3'd2, 1, 0, 0};
        vecs[13] = '{1, 1, 4'h0, 4'b0001, 3'd0, 1, 0, 0};     // abort, word dropped
        vecs[14] = '{0, 1, 4'h0, 4'b0011, 3'd1, 1, 0, 0};
        vecs[15] = '{0, 0, 4'h0, 4'b0011, 3'd1, 1, 0, 0};
        vecs[16] = '{0, 1, 4'h0, 4'b0111, 3'd2, 1, 0, 0};
        vecs[17] = '{0, 1, 4'h0, 4'b1111, 3'd3, 1, 0, 0};
        vecs[18] = '{0, 1, 4'h0, 4'b1110, 3'd4, 0, 1, CmpEn};
        vecs[19] = '{0, 1, 4'h3, 4'b1110, 3'd4, 0, 1, CmpEn};

        // Reset values.
        #1 rst = 1'b1;
        #2;
        chk("rst_sig", 32'(sig_a), 32'h1);
        chk("rst_cnt", 32'(cnt_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_pass", 32'(pass_a), 32'h0);
        chk("rst_sig_b", 32'(sig_b), 32'h0);
        step();
        rst = 1'b0;
        step();

        // Table-driven run on instance A.
        for (int i = 0; i < 20; i++) begin
            start_a = vecs[i].start;
            valid_a = vecs[i].valid;
            din_a   = vecs[i].din;
            step();
            chk($sformatf("v%0d_sig", i), 32'(sig_a), 32'(vecs[i].sig));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i), 32'(vecs[i].done ? done_a : done_a), 32'(vecs[i].done));
            chk($sformatf("v%0d_pass", i), 32'(pass_a), 32'(vecs[i].pass));
        end
        start_a = 0; valid_a = 0;

        // Instances B/C: data-dependent words and pass/fail comparison.
        start_b = 1; step();
        chk("b_start_sig", 32'(sig_b), 32'h0);
        chk("b_start_busy", 32'(busy_b), 32'h1);
        start_b = 0; valid_b = 1; din_b = 4'hA; step();
        chk("b_w1_sig", 32'(sig_b), 32'hA);
        chk("b_w1_cnt", 32'(cnt_b), 32'h1);
        chk("b_w1_done", 32'(done_b), 32'h0);
        din_b = 4'h5; step();
        chk("b_w2_sig", 32'(sig_b), 32'h0);
        chk("b_w2_cnt", 32'(cnt_b), 32'h2);
        chk("b_w2_done", 32'(done_b), 32'h1);
        chk("b_w2_busy", 32'(busy_b), 32'h0);
        chk("b_pass_golden0", 32'(pass_b), 32'(CmpEn));
        chk("c_pass_golden1", 32'(pass_c), 32'h0);
        chk("c_w2_sig", 32'(sig_c), 32'h0);
        din_b = 4'hF; step();
        chk("b_frozen_sig", 32'(sig_b), 32'h0);
        chk("b_frozen_cnt", 32'(cnt_b), 32'h2);
        chk("b_frozen_pass", 32'(pass_b), 32'(CmpEn));
        valid_b = 0;

        // Asynchronous reset mid-session on A.
        start_a = 1; step();
        start_a = 0; valid_a = 1; din_a = 4'h0; step(); step();
        chk("pre_rst_sig", 32'(sig_a), 32'h7);
        valid_a = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sig", 32'(sig_a), 32'h1);
        chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        chk("mid_rst_done", 32'(done_a), 32'h0);
        chk("mid_rst_done_b", 32'(done_b), 32'h0);
        chk("mid_rst_pass_b", 32'(pass_b), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
